// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller.
// PC_CTRL_EXC_EN enables the exception-entry constants.
package pc_ctrl_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [PC_W-1:0] PC_STEP  = 32'h0000_0004;
`ifdef PC_CTRL_EXC_EN
   localparam logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0080;
`endif

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_REDIR = 2'd3
   } state_e;

   // Redirect targets are word aligned; low address bits are discarded.
   function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority selector: exception > branch > jump > hold > +4.
// Exception input and select exist only when PC_CTRL_EXC_EN is defined.
module pc_next_sel
   import pc_ctrl_pkg::*;
(
   input  logic [PC_W-1:0] pc,
`ifdef PC_CTRL_EXC_EN
   input  logic            exc_req,
   output logic            exc_sel_c,
`endif
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            stall,
   input  logic            imem_ready,
   output logic [PC_W-1:0] next_pc_c,
   output logic            redirect_c,
   output logic            hold_c
);

   assign hold_c = stall | ~imem_ready;

   always_comb begin
      next_pc_c  = pc + PC_STEP;
      redirect_c = 1'b0;
`ifdef PC_CTRL_EXC_EN
      exc_sel_c  = 1'b0;
      if (exc_req) begin
         next_pc_c  = EXC_VECTOR;
         redirect_c = 1'b1;
         exc_sel_c  = 1'b1;
      end else
`endif
      if (br_taken) begin
         next_pc_c  = align_word(br_target);
         redirect_c = 1'b1;
      end else if (jmp) begin
         next_pc_c  = align_word(jmp_target);
         redirect_c = 1'b1;
      end else if (hold_c) begin
         next_pc_c  = pc;
      end
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: owns the PC register and the BOOT/RUN/HOLD/REDIR sequencing.
// Define PC_CTRL_EXC_EN to honour exc_req and capture the faulting PC in o_epc.
module pc_ctrl
   import pc_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            imem_ready,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            exc_req,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_plus4,
   output logic            o_fetch_valid,
   output logic            o_flush,
   output logic [PC_W-1:0] o_epc
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            flush_q, flush_d;
   logic [PC_W-1:0] sel_next_pc;
   logic            sel_redirect;
   logic            sel_hold;

`ifdef PC_CTRL_EXC_EN
   logic            sel_exc;
   logic [PC_W-1:0] epc_q, epc_d;
`else
   logic            unused_exc_req;
   assign unused_exc_req = exc_req;
`endif

   pc_next_sel u_next_sel (
      .pc         (pc_q),
`ifdef PC_CTRL_EXC_EN
      .exc_req    (exc_req),
      .exc_sel_c  (sel_exc),
`endif
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .stall      (stall),
      .imem_ready (imem_ready),
      .next_pc_c  (sel_next_pc),
      .redirect_c (sel_redirect),
      .hold_c     (sel_hold)
   );

   // Next state; valid/flush are derived from the next state so they leave a flop.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_CTRL_EXC_EN
      epc_d   = epc_q;
`endif
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         default: begin
            pc_d = sel_next_pc;
            if (sel_redirect) begin
               state_d = ST_REDIR;
            end else if (sel_hold) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_RUN;
            end
`ifdef PC_CTRL_EXC_EN
            if (sel_exc) begin
               epc_d = pc_q;
            end
`endif
         end
      endcase
      fetch_valid_d = (state_d != ST_BOOT);
      flush_d       = (state_d == ST_REDIR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
`ifdef PC_CTRL_EXC_EN
         epc_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
`ifdef PC_CTRL_EXC_EN
         epc_q         <= epc_d;
`endif
      end
   end

   assign o_pc          = pc_q;
   assign o_pc_plus4    = pc_q + PC_STEP;
   assign o_fetch_valid = fetch_valid_q;
   assign o_flush       = flush_q;
`ifdef PC_CTRL_EXC_EN
   assign o_epc         = epc_q;
`else
   assign o_epc         = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, reset corner case, random run vs. model.
module tb_pc_ctrl;

`ifdef PC_CTRL_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif
   localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] T_EXC_VEC  = 32'h0000_0080;
   localparam logic [31:0] X_PC  = EXC_EN ? T_EXC_VEC : 32'h0000_0500;
   localparam logic [31:0] X_EPC = EXC_EN ? 32'h0000_0040 : 32'h0000_0000;

   logic        clk, rst_n;
   logic        imem_ready, stall, br_taken, jmp, exc_req;
   logic [31:0] br_target, jmp_target;
   logic [31:0] o_pc, o_pc_plus4, o_epc;
   logic        o_fetch_valid, o_flush;

   int total = 0;
   int bad   = 0;

   pc_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .jmp           (jmp),
      .jmp_target    (jmp_target),
      .exc_req       (exc_req),
      .o_pc          (o_pc),
      .o_pc_plus4    (o_pc_plus4),
      .o_fetch_valid (o_fetch_valid),
      .o_flush       (o_flush),
      .o_epc         (o_epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic        r;
      logic        b;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic        e;
      logic [31:0] exp_pc;
      logic        exp_flush;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: what the fetch unit should present.
   logic        m_boot;
   logic [31:0] m_pc, m_epc;
   logic        m_valid, m_flush;

   function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic e,
                               input logic [31:0] pc, input logic f, input logic [31:0] epc);
      vec_t v;
      v.s = s; v.r = r; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.e = e;
      v.exp_pc = pc; v.exp_flush = f; v.exp_epc = epc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic r, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic e);
      stall = s; imem_ready = r; br_taken = b; br_target = bt;
      jmp = j; jmp_target = jt; exc_req = e;
   endtask

   task automatic model_reset();
      m_boot = 1'b1; m_pc = T_RESET_PC; m_epc = 32'h0;
      m_valid = 1'b0; m_flush = 1'b0;
   endtask

   // One clock of the spec's behaviour, applied to the inputs seen at that edge.
   task automatic model_step();
      logic [31:0] tgt;
      logic        redirect;
      if (m_boot) begin
         m_boot = 1'b0; m_valid = 1'b1; m_flush = 1'b0;
         return;
      end
      redirect = 1'b1;
      tgt = 32'h0;
      if (EXC_EN && exc_req) begin
         tgt = T_EXC_VEC;
         m_epc = m_pc;
      end else if (br_taken) begin
         tgt = br_target & 32'hFFFF_FFFC;
      end else if (jmp) begin
         tgt = jmp_target & 32'hFFFF_FFFC;
      end else begin
         redirect = 1'b0;
      end
      m_valid = 1'b1;
      m_flush = redirect;
      if (redirect) m_pc = tgt;
      else if (imem_ready && !stall) m_pc = m_pc + 32'd4;
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".pc"},    o_pc, m_pc);
      chk({tag, ".plus4"}, o_pc_plus4, m_pc + 32'd4);
      chk({tag, ".valid"}, 32'(o_fetch_valid), 32'(m_valid));
      chk({tag, ".flush"}, 32'(o_flush), 32'(m_flush));
      chk({tag, ".epc"},   o_epc, m_epc);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Directed table: expected values are taken straight from the fetch rules.
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0000,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0004,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0008,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_000C,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0010,0,32'h0));
      vecs.push_back(mk(0,1,1,32'h0000_0103,0,32'h0,0, 32'h0000_0100,1,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0104,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,1,32'h0000_001C,0, 32'h0000_001C,1,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0020,0,32'h0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0,32'h0,0,32'h0,0, 32'h0000_0020,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0024,0,32'h0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0, 32'h0000_0024,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0028,0,32'h0));
      vecs.push_back(mk(1,1,1,32'h0000_0200,1,32'h0000_0300,0, 32'h0000_0200,1,32'h0));
      vecs.push_back(mk(1,1,0,32'h0,0,32'h0,0, 32'h0000_0200,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0204,0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,1,32'h0000_003C,0, 32'h0000_003C,1,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0040,0,32'h0));
      vecs.push_back(mk(0,1,1,32'h0000_0500,0,32'h0,1, X_PC,1,X_EPC));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, X_PC + 32'd4,0,X_EPC));
      vecs.push_back(mk(0,1,0,32'h0,1,32'hFFFF_FFFC,0, 32'hFFFF_FFFC,1,X_EPC));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0000,0,X_EPC));
      vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0, 32'h0000_0004,0,X_EPC));
      vecs.push_back(mk(0,1,0,32'h0,1,32'h0000_0063,0, 32'h0000_0060,1,X_EPC));
      vecs.push_back(mk(1,1,0,32'h0,0,32'h0,0, 32'h0000_0060,0,X_EPC));

      // Reset values while held in reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst.pc",    o_pc, T_RESET_PC);
      chk("rst.plus4", o_pc_plus4, T_RESET_PC + 32'd4);
      chk("rst.valid", 32'(o_fetch_valid), 32'h0);
      chk("rst.flush", 32'(o_flush), 32'h0);
      chk("rst.epc",   o_epc, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].s, vecs[i].r, vecs[i].b, vecs[i].bt, vecs[i].j, vecs[i].jt, vecs[i].e);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.pc", i),    o_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d.plus4", i), o_pc_plus4, vecs[i].exp_pc + 32'd4);
         chk($sformatf("vec%0d.valid", i), 32'(o_fetch_valid), 32'h1);
         chk($sformatf("vec%0d.flush", i), 32'(o_flush), 32'(vecs[i].exp_flush));
         chk($sformatf("vec%0d.epc", i),   o_epc, vecs[i].exp_epc);
         @(negedge clk);
      end

      // Async reset mid-HOLD at 0x60, then BOOT for one cycle on release
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.pc",    o_pc, T_RESET_PC);
      chk("arst.plus4", o_pc_plus4, T_RESET_PC + 32'd4);
      chk("arst.valid", 32'(o_fetch_valid), 32'h0);
      chk("arst.flush", 32'(o_flush), 32'h0);
      chk("arst.epc",   o_epc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      chk("boot.valid", 32'(o_fetch_valid), 32'h1);
      chk("boot.pc",    o_pc, T_RESET_PC);
      @(posedge clk);
      #1;
      chk("boot.adv", o_pc, T_RESET_PC + 32'd4);

      // Randomised run against the model, with occasional async resets
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            compare_model("rnd_rst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0, $urandom,
               $urandom_range(0, 7) == 0, $urandom,
               $urandom_range(0, 15) == 0);
         if ($urandom_range(0, 63) == 0) begin
            br_taken = 1'b0; jmp = 1'b1; exc_req = 1'b0; jmp_target = 32'hFFFF_FFFC;
         end
         @(posedge clk);
         model_step();
         #1;
         compare_model($sformatf("rnd%0d", i));
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
